// File: rtl/opamp_bist_sequencer.sv
// Purpose: powers the op_amp, applies six differential input vectors and checks each sampled output against a window.
// Latency: start to first apply 1+PWR_CYCLES+1 cycles, apply to result_valid SETTLE_CYCLES+1, full run PWR_CYCLES+6*(SETTLE_CYCLES+2)+2.
// Backpressure: none; start is dropped unless idle, and result pulses are not held for a consumer.
module opamp_bist_sequencer #(
   parameter int DATA_W        = 16,
   parameter int PWR_CYCLES    = 5,
   parameter int SETTLE_CYCLES = 5,
   parameter int VCC_CODE      = 15000,
   parameter int VEE_CODE      = -15000
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   output logic signed [DATA_W-1:0] inv_out,
   output logic signed [DATA_W-1:0] noninv_out,
   output logic signed [DATA_W-1:0] vcc_out,
   output logic signed [DATA_W-1:0] vee_out,
   output logic                     offset_null_out,
   input  logic signed [DATA_W-1:0] amp_in,
   output logic                     busy,
   output logic [2:0]               test_idx,
   output logic                     result_valid,
   output logic                     result_pass,
   output logic [2:0]               pass_cnt,
   output logic [2:0]               fail_cnt,
   output logic                     done,
   output logic                     all_pass
);

   // One shared counter serves both the power-up wait and the settle wait.
   localparam int CNT_MAX = (PWR_CYCLES > SETTLE_CYCLES) ? PWR_CYCLES : SETTLE_CYCLES;
   localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
   localparam logic [CNT_W-1:0] PWR_LAST    = CNT_W'(PWR_CYCLES - 1);
   localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
   localparam logic [2:0]       LAST_IDX    = 3'd5;

   typedef enum logic [2:0] {
      S_IDLE,
      S_POWER,
      S_APPLY,
      S_SETTLE,
      S_SAMPLE,
      S_DONE
   } state_t;

   typedef struct packed {
      logic signed [DATA_W-1:0] inv;
      logic signed [DATA_W-1:0] noninv;
      logic signed [DATA_W-1:0] lo;
      logic signed [DATA_W-1:0] hi;
   } vec_t;

   // Fixed stimulus table; lo/hi are exclusive window bounds on the sampled output.
   function automatic vec_t rom_lookup(input logic [2:0] idx);
      vec_t v;
      v.inv    = '0;
      v.noninv = '0;
      v.lo     = '0;
      v.hi     = '0;
      case (idx)
         3'd0: begin
            v.inv = DATA_W'(100);  v.noninv = DATA_W'(110);
            v.lo  = DATA_W'(0);    v.hi     = DATA_W'(32767);
         end
         3'd1: begin
            v.inv = DATA_W'(110);  v.noninv = DATA_W'(100);
            v.lo  = DATA_W'(-32768); v.hi   = DATA_W'(0);
         end
         3'd2: begin
            v.inv = DATA_W'(0);    v.noninv = DATA_W'(500);
            v.lo  = DATA_W'(12000); v.hi    = DATA_W'(14000);
         end
         3'd3: begin
            v.inv = DATA_W'(500);  v.noninv = DATA_W'(0);
            v.lo  = DATA_W'(-14000); v.hi   = DATA_W'(-12000);
         end
         3'd4: begin
            v.inv = DATA_W'(200);  v.noninv = DATA_W'(200);
            v.lo  = DATA_W'(-1000); v.hi    = DATA_W'(1000);
         end
         3'd5: begin
            v.inv = DATA_W'(0);    v.noninv = DATA_W'(0);
            v.lo  = DATA_W'(-1000); v.hi    = DATA_W'(1000);
         end
         default: begin
            v.inv = '0; v.noninv = '0; v.lo = '0; v.hi = '0;
         end
      endcase
      return v;
   endfunction

   state_t                   state, state_nxt;
   logic [CNT_W-1:0]         cnt, cnt_nxt;
   logic signed [DATA_W-1:0] inv_nxt, noninv_nxt, vcc_nxt, vee_nxt;
   logic                     busy_nxt, result_valid_nxt, result_pass_nxt;
   logic                     done_nxt, all_pass_nxt;
   logic [2:0]               test_idx_nxt, pass_cnt_nxt, fail_cnt_nxt;
   vec_t                     rom_cur;
   logic                     in_window;

   assign offset_null_out = 1'b0;
   assign rom_cur         = rom_lookup(test_idx);
   assign in_window       = ($signed(amp_in) > $signed(rom_cur.lo)) &&
                            ($signed(amp_in) < $signed(rom_cur.hi));

   // Next-state and next-output decode; every register holds unless its state says otherwise.
   always_comb begin
      state_nxt        = state;
      cnt_nxt          = cnt;
      inv_nxt          = inv_out;
      noninv_nxt       = noninv_out;
      vcc_nxt          = vcc_out;
      vee_nxt          = vee_out;
      busy_nxt         = busy;
      test_idx_nxt     = test_idx;
      result_valid_nxt = 1'b0;
      result_pass_nxt  = 1'b0;
      pass_cnt_nxt     = pass_cnt;
      fail_cnt_nxt     = fail_cnt;
      done_nxt         = done;
      all_pass_nxt     = all_pass;
      case (state)
         S_IDLE: begin
            if (start) begin
               pass_cnt_nxt = '0;
               fail_cnt_nxt = '0;
               done_nxt     = 1'b0;
               all_pass_nxt = 1'b0;
               busy_nxt     = 1'b1;
               test_idx_nxt = '0;
               vcc_nxt      = DATA_W'(VCC_CODE);
               vee_nxt      = DATA_W'(VEE_CODE);
               inv_nxt      = '0;
               noninv_nxt   = '0;
               cnt_nxt      = '0;
               state_nxt    = S_POWER;
            end
         end
         S_POWER: begin
            if (cnt == PWR_LAST) begin
               cnt_nxt   = '0;
               state_nxt = S_APPLY;
            end else begin
               cnt_nxt = cnt + CNT_W'(1);
            end
         end
         S_APPLY: begin
            inv_nxt    = rom_cur.inv;
            noninv_nxt = rom_cur.noninv;
            cnt_nxt    = '0;
            state_nxt  = S_SETTLE;
         end
         S_SETTLE: begin
            if (cnt == SETTLE_LAST) begin
               cnt_nxt   = '0;
               state_nxt = S_SAMPLE;
            end else begin
               cnt_nxt = cnt + CNT_W'(1);
            end
         end
         S_SAMPLE: begin
            result_valid_nxt = 1'b1;
            result_pass_nxt  = in_window;
            if (in_window) begin
               pass_cnt_nxt = pass_cnt + 3'd1;
            end else begin
               fail_cnt_nxt = fail_cnt + 3'd1;
            end
            if (test_idx == LAST_IDX) begin
               state_nxt = S_DONE;
            end else begin
               test_idx_nxt = test_idx + 3'd1;
               state_nxt    = S_APPLY;
            end
         end
         S_DONE: begin
            inv_nxt      = '0;
            noninv_nxt   = '0;
            busy_nxt     = 1'b0;
            done_nxt     = 1'b1;
            all_pass_nxt = (fail_cnt == 3'd0);
            state_nxt    = S_IDLE;
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   // State and output registers; reset drops everything, supplies included.
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= S_IDLE;
         cnt          <= '0;
         inv_out      <= '0;
         noninv_out   <= '0;
         vcc_out      <= '0;
         vee_out      <= '0;
         busy         <= 1'b0;
         test_idx     <= '0;
         result_valid <= 1'b0;
         result_pass  <= 1'b0;
         pass_cnt     <= '0;
         fail_cnt     <= '0;
         done         <= 1'b0;
         all_pass     <= 1'b0;
      end else begin
         state        <= state_nxt;
         cnt          <= cnt_nxt;
         inv_out      <= inv_nxt;
         noninv_out   <= noninv_nxt;
         vcc_out      <= vcc_nxt;
         vee_out      <= vee_nxt;
         busy         <= busy_nxt;
         test_idx     <= test_idx_nxt;
         result_valid <= result_valid_nxt;
         result_pass  <= result_pass_nxt;
         pass_cnt     <= pass_cnt_nxt;
         fail_cnt     <= fail_cnt_nxt;
         done         <= done_nxt;
         all_pass     <= all_pass_nxt;
      end
   end

endmodule

// File: doc/opamp_bist_sequencer.md
Name: opamp_bist_sequencer

Overview:
- On-chip stimulus/response engine for the op_amp IC. It is the driving and checking end of the op_amp pin interface.
- Powers the device with fixed supply codes, then applies a fixed table of six differential input vectors on the inverting and non-inverting pins.
- After a programmable settle time it samples the output pin and checks it against a per-vector window.
- Reports per-vector results and pass/fail totals to the system, replacing manual bench stimulus.

Parameters:
- DATA_W, 16, width of all signed analog-code buses.
- PWR_CYCLES, 5, clock cycles that supplies are held before the first vector.
- SETTLE_CYCLES, 5, clock cycles from vector apply to output sample (minimum 1).
- VCC_CODE, 15000, code driven on vcc_out (+15 V).
- VEE_CODE, -15000, code driven on vee_out (-15 V).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a test run when idle.
- inv_out  out  DATA_W signed  drive to op_amp pin2_inv_input.
- noninv_out  out  DATA_W signed  drive to op_amp pin3_noninv_input.
- vcc_out  out  DATA_W signed  drive to pin7_vcc.
- vee_out  out  DATA_W signed  drive to pin4_vee.
- offset_null_out  out  1  drive to pin1/pin5, constant 0.
- amp_in  in  DATA_W signed  from op_amp pin6_output.
- busy  out  1  high from accepted start until done.
- test_idx  out  3  index 0..5 of the vector in progress.
- result_valid  out  1  one-cycle pulse per sampled vector.
- result_pass  out  1  pass flag for that vector; valid only with result_valid.
- pass_cnt  out  3  vectors passed in the current or last run.
- fail_cnt  out  3  vectors failed in the current or last run.
- done  out  1  level; high after a run completes, cleared by the next accepted start.
- all_pass  out  1  level; valid when done; high iff fail_cnt==0.

Behaviour:
- Interface decision: one clock `clk`. Reset `rst` is synchronous and active-high.
- Reset values: all outputs 0. This includes the supply codes (device unpowered) and test_idx. The FSM enters IDLE.
- Vector ROM, indexed by test_idx. Each entry is (inv, noninv, lo, hi). Pass condition is lo < amp_in < hi, strict and signed.
  - 0: (100, 110, 0, 32767)
  - 1: (110, 100, -32768, 0)
  - 2: (0, 500, 12000, 14000)
  - 3: (500, 0, -14000, -12000)
  - 4: (200, 200, -1000, 1000)
  - 5: (0, 0, -1000, 1000)
- IDLE:
  - Supplies are 0 on the first entry after reset. After a completed run they hold their last value.
  - On start: clear pass_cnt, fail_cnt and done; set busy and test_idx=0; drive vcc_out/vee_out to VCC_CODE/VEE_CODE; drive inputs to 0; go to POWER.
- POWER: count PWR_CYCLES cycles, then go to APPLY.
- APPLY, one cycle:
  - Register inv_out/noninv_out from ROM[test_idx].
  - Clear the settle counter; go to SETTLE.
- SETTLE: count SETTLE_CYCLES cycles, then go to SAMPLE.
- SAMPLE, one cycle:
  - Register the comparison of amp_in against the window.
  - Pulse result_valid with result_pass.
  - Increment pass_cnt or fail_cnt.
  - If test_idx==5, go to DONE; otherwise increment test_idx and go to APPLY.
- DONE:
  - Drive inv_out=noninv_out=0; clear busy; set done and all_pass.
  - Supplies stay on; go to IDLE.
- Latency:
  - start to first apply: 1 + PWR_CYCLES + 1 cycles.
  - apply to result_valid: SETTLE_CYCLES + 1 cycles.
  - full run: deterministic; PWR_CYCLES + 6*(SETTLE_CYCLES + 2) + 2 cycles.
- Boundary conditions:
  - start while busy is ignored, with no restart and no counter effect.
  - start in the same cycle as the DONE transition is ignored. A start in a later IDLE cycle is accepted.
  - rst mid-run takes priority over everything. The FSM returns to IDLE within 1 cycle and all outputs drop to reset values, including supplies.
  - amp_in exactly equal to lo or hi fails.
  - Comparison is full-width signed with no overflow; the ROM bounds fit in DATA_W.
  - pass_cnt + fail_cnt == 6 at done.

Test Plan:
- Ideal model (gain 100, clipped to ±13000, 1-cycle lag) → six result_valid pulses with result_pass=1; pass_cnt=6, fail_cnt=0, all_pass=1; done asserted exactly PWR_CYCLES+6*(SETTLE_CYCLES+2)+2 cycles after start.
- Model with output stuck at 0 → vectors 0–3 fail, 4–5 pass; pass_cnt=2, fail_cnt=4, all_pass=0.
- Model saturating at ±14000 (boundary) → vectors 2 and 3 fail on the strict bound; fail_cnt=2.
- start pulsed again at cycle 10 of a run → ignored; run completes with the same timing and results.
- rst asserted during SETTLE of vector 3 → next cycle busy=0, vcc_out=vee_out=0, counters 0. A fresh start then completes normally with pass_cnt=6.
- Back-to-back runs: start 1 cycle after done → counters clear and done drops on acceptance; the second run's totals are independent of the first.
